multi_reg_sequencer: RTL
========================

# multi_reg_sequencer

Sequences multi-register load/store instructions (PUSH/POP, LDM/STM) into one single-register micro-op per cycle. Drives the ALU operand selects and control so the execute stage computes each transfer address as base + 4·k. Holds the front of the pipeline while the sequence runs. Sits between decode and the execute-stage ALU wrapper, in parallel with the normal decode path.

## Interface
- REG_LIST_W, 8, width of the register-list field (low registers r0..r7)
- clk_i  in  1  core clock
- reset_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  decoded multi-register instruction present
- is_valid_i  in  1  decode slot holds a valid instruction; start is ignored without it
- is_load_i  in  1  1 = load (POP/LDM), 0 = store (PUSH/STM)
- writeback_i  in  1  base register is updated at end of sequence
- reg_list_i  in  REG_LIST_W  register bitmap, bit k = rk
- base_reg_i  in  4  base register index
- mem_stall_i  in  1  memory cannot accept the current micro-op; hold it
- busy_o  out  1  sequence in progress
- stall_pipeline_o  out  1  freeze fetch/decode
- uop_valid_o  out  1  micro-op presented this cycle
- uop_reg_o  out  4  transfer register of the micro-op
- uop_is_load_o  out  1  micro-op direction
- uop_is_writeback_o  out  1  micro-op is the base-update op
- alu_ctrl_sig_o  out  alu_control_signal  always ALU_ADD while uop_valid_o is high
- alu_input_1_select_o  out  alu_input_source  FROM_REG (base)
- alu_input_2_select_o  out  alu_input_source  FROM_IMM (offset)
- offset_o  out  WORD  immediate fed to the ALU
- done_o  out  1  one-cycle pulse: sequence finished

## Operation
- States: IDLE, ISSUE, WB.
- IDLE
  - Latches on start_i & is_valid_i: pending_mask ← reg_list_i, offset ← 0, direction, base and a wb_pending flag.
  - Non-zero list → ISSUE.
  - Zero list → stays IDLE, pulses done_o next cycle, issues no micro-ops.
- ISSUE
  - uop_valid_o = 1.
  - uop_reg_o = index of the lowest set bit of pending_mask.
  - offset_o = current offset.
  - If !mem_stall_i: clear that bit, offset += 4.
  - If !mem_stall_i and that bit was the last set bit: go to WB if wb_pending, else IDLE with done_o.
  - If mem_stall_i: all uop outputs hold unchanged.
- WB
  - uop_valid_o = 1, uop_is_writeback_o = 1, uop_reg_o = base, offset_o = 4·popcount(list).
  - If !mem_stall_i: → IDLE, done_o pulses.
- wb_pending = writeback_i & ~(is_load_i & reg_list_i[base_reg_i]). For a load whose base is in the list, the loaded value wins and no WB op is issued.
- Offset arithmetic is WORD wide with no wrap concern (max 4·REG_LIST_W).
- While busy, start_i is ignored.
- busy_o = stall_pipeline_o = (state != IDLE).
- update_flag is never requested; the sequencer does not touch status flags.

## Timing
- Start accepted at edge N; first micro-op is visible in cycle N+1.
- Without stalls, each set bit takes one cycle, plus one cycle for WB.
- done_o is registered: it is high the cycle after the final op is accepted, coincident with IDLE.
- Reset (asynchronous, any state): state IDLE, pending_mask 0, offset 0, all 1-bit outputs 0, uop_reg_o 0, offset_o 0, selects FROM_ZERO, alu_ctrl_sig_o ALU_ADD.
- A reset mid-sequence drops all remaining ops; no done_o is produced.
- mem_stall_i asserted on the final op delays the state change and done_o by the stall length.

## Configuration
- MULTI_REG_WRITEBACK_EN
  - Defined: WB state and writeback behaviour as above.
  - Undefined: writeback_i is ignored, the WB state is not built, and uop_is_writeback_o is tied to 0. The base update is then handled by a separate decoded instruction.

## Structure
- Shared package:
  - seq_state_t enum (IDLE/ISSUE/WB).
  - ADDR_STRIDE = 4.
  - Reuses WORD, alu_control_signal and alu_input_source.
- Sub-module lowest_set_bit: combinational priority encoder, REG_LIST_W in → index plus any-set flag. It is also used for the last-bit check (the mask with the lowest bit cleared is zero).

## Test plan
- Store, list 8'b0000_0101, base r1, no writeback → uops (r0, offset 0), (r2, offset 4); done_o in cycle 3; stall_pipeline_o high cycles 1–2.
- Same list with mem_stall_i high for 2 cycles on the first op → r0/offset 0 held for 3 cycles, then r2; done_o delayed by 2.
- Writeback on, store, list 8'h0F, base r5 → r0..r3 at offsets 0, 4, 8, 12, then WB op with uop_reg_o = 5 and offset 16; done_o after 5 ops.
- Load, list 8'h12, base r4, writeback on → r1, r4 only, no WB op (base in list).
- Empty list → zero micro-ops, done_o pulse one cycle after start, busy_o stays 0.
- reset_n_i low during the second op of list 8'hFF → outputs at reset values immediately; a new start afterwards begins at r0, offset 0.

Source files
------------

// File: rtl/multi_reg_sequencer_pkg.sv
// Shared types for the multi-register load/store sequencer.
// Optional feature macro: MULTI_REG_WRITEBACK_EN (builds the base-update WB op).
package multi_reg_sequencer_pkg;

    typedef logic [31:0] WORD;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SHL,
        ALU_SHR,
        ALU_PASS
    } alu_control_signal;

    typedef enum logic [1:0] {
        FROM_ZERO,
        FROM_REG,
        FROM_IMM,
        FROM_PC
    } alu_input_source;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WB
    } seq_state_t;

    // Register-list width: low registers r0..r7
    localparam int REG_LIST_W  = 8;
    localparam int ADDR_STRIDE = 4;

endpackage

// File: rtl/multi_reg_sequencer_if.sv
// Decode-side request and execute-side micro-op bundle of the sequencer.
interface multi_reg_sequencer_if;
    import multi_reg_sequencer_pkg::*;

    logic                  start_i;
    logic                  is_valid_i;
    logic                  is_load_i;
    logic                  writeback_i;
    logic [REG_LIST_W-1:0] reg_list_i;
    logic [3:0]            base_reg_i;
    logic                  mem_stall_i;

    logic                  busy_o;
    logic                  stall_pipeline_o;
    logic                  uop_valid_o;
    logic [3:0]            uop_reg_o;
    logic                  uop_is_load_o;
    logic                  uop_is_writeback_o;
    alu_control_signal     alu_ctrl_sig_o;
    alu_input_source       alu_input_1_select_o;
    alu_input_source       alu_input_2_select_o;
    WORD                   offset_o;
    logic                  done_o;

    // Decode / execute side
    modport master (
        output start_i, is_valid_i, is_load_i, writeback_i, reg_list_i,
               base_reg_i, mem_stall_i,
        input  busy_o, stall_pipeline_o, uop_valid_o, uop_reg_o, uop_is_load_o,
               uop_is_writeback_o, alu_ctrl_sig_o, alu_input_1_select_o,
               alu_input_2_select_o, offset_o, done_o
    );

    // Sequencer side
    modport slave (
        input  start_i, is_valid_i, is_load_i, writeback_i, reg_list_i,
               base_reg_i, mem_stall_i,
        output busy_o, stall_pipeline_o, uop_valid_o, uop_reg_o, uop_is_load_o,
               uop_is_writeback_o, alu_ctrl_sig_o, alu_input_1_select_o,
               alu_input_2_select_o, offset_o, done_o
    );

endinterface

// File: rtl/multi_reg_sequencer_lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit plus any-set flag.
module lowest_set_bit #(
    parameter  int W  = 8,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan from the top down so the lowest set bit is the last to win
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int k = W - 1; k >= 0; k--) begin
            if (vec_i[k]) begin
                idx_o = IW'(k);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_reg_sequencer.sv
// Splits PUSH/POP/LDM/STM into one single-register micro-op per cycle,
// steering the ALU to compute base + 4*k for each transfer.
// Optional feature macro: MULTI_REG_WRITEBACK_EN (final base-update WB op).
module multi_reg_sequencer
    import multi_reg_sequencer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    multi_reg_sequencer_if.slave  sif
);

    localparam int IW = $clog2(REG_LIST_W);

    seq_state_t            state_q, state_d;
    logic [REG_LIST_W-1:0] mask_q, mask_d;
    WORD                   offset_q, offset_d;
    logic                  is_load_q, is_load_d;
    logic [3:0]            base_q, base_d;
    logic                  wb_pend_q, wb_pend_d;
    logic                  done_q, done_d;

    logic [IW-1:0]         lsb_idx;
    logic                  lsb_any;
    logic [REG_LIST_W-1:0] rest_mask;
    logic [IW-1:0]         unused_rest_idx;
    logic                  rest_any;
    logic                  base_in_list;
    logic                  wb_req;

    lowest_set_bit #(.W(REG_LIST_W)) u_lsb (
        .vec_i (mask_q),
        .idx_o (lsb_idx),
        .any_o (lsb_any)
    );

    // Remaining list once the current op retires; empty means this op is the last
    assign rest_mask = mask_q & ~(REG_LIST_W'(1) << lsb_idx);

    lowest_set_bit #(.W(REG_LIST_W)) u_last (
        .vec_i (rest_mask),
        .idx_o (unused_rest_idx),
        .any_o (rest_any)
    );

    // Base registers above r7 can never be in the list
    always_comb begin
        base_in_list = 1'b0;
        for (int k = 0; k < REG_LIST_W; k++) begin
            if (sif.base_reg_i == 4'(k)) base_in_list = sif.reg_list_i[k];
        end
    end

`ifdef MULTI_REG_WRITEBACK_EN
    // A load that targets its own base keeps the loaded value: no base update
    assign wb_req = sif.writeback_i & ~(sif.is_load_i & base_in_list);
`else
    logic unused_wb;
    assign unused_wb = sif.writeback_i ^ base_in_list;
    assign wb_req    = 1'b0;
`endif

    // State and sequence context registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            offset_q  <= '0;
            is_load_q <= 1'b0;
            base_q    <= '0;
            wb_pend_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            offset_q  <= offset_d;
            is_load_q <= is_load_d;
            base_q    <= base_d;
            wb_pend_q <= wb_pend_d;
            done_q    <= done_d;
        end
    end

    // Next-state and micro-op outputs; outputs depend only on registered state,
    // so a memory stall holds them unchanged
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        offset_d  = offset_q;
        is_load_d = is_load_q;
        base_d    = base_q;
        wb_pend_d = wb_pend_q;
        done_d    = 1'b0;

        sif.uop_valid_o          = 1'b0;
        sif.uop_reg_o            = '0;
        sif.uop_is_load_o        = 1'b0;
        sif.uop_is_writeback_o   = 1'b0;
        sif.alu_ctrl_sig_o       = ALU_ADD;
        sif.alu_input_1_select_o = FROM_ZERO;
        sif.alu_input_2_select_o = FROM_ZERO;
        sif.offset_o             = '0;

        case (state_q)
            IDLE: begin
                if (sif.start_i && sif.is_valid_i) begin
                    mask_d    = sif.reg_list_i;
                    offset_d  = '0;
                    is_load_d = sif.is_load_i;
                    base_d    = sif.base_reg_i;
                    wb_pend_d = wb_req;
                    if (|sif.reg_list_i) state_d = ISSUE;
                    else                 done_d  = 1'b1;
                end
            end
            ISSUE: begin
                sif.uop_valid_o          = lsb_any;
                sif.uop_reg_o            = 4'(lsb_idx);
                sif.uop_is_load_o        = is_load_q;
                sif.alu_input_1_select_o = FROM_REG;
                sif.alu_input_2_select_o = FROM_IMM;
                sif.offset_o             = offset_q;
                if (!sif.mem_stall_i) begin
                    mask_d   = rest_mask;
                    offset_d = offset_q + WORD'(ADDR_STRIDE);
                    if (!rest_any) begin
                        if (wb_pend_q) begin
                            state_d = WB;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
`ifdef MULTI_REG_WRITEBACK_EN
            WB: begin
                // offset_q has advanced by one stride per transfer: 4*popcount
                sif.uop_valid_o          = 1'b1;
                sif.uop_is_writeback_o   = 1'b1;
                sif.uop_reg_o            = base_q;
                sif.uop_is_load_o        = is_load_q;
                sif.alu_input_1_select_o = FROM_REG;
                sif.alu_input_2_select_o = FROM_IMM;
                sif.offset_o             = offset_q;
                if (!sif.mem_stall_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign sif.busy_o           = (state_q != IDLE);
    assign sif.stall_pipeline_o = (state_q != IDLE);
    assign sif.done_o           = done_q;

endmodule
